// File: rtl/player_ctrl_if.sv
// Player controller bus: button/self_state in from the board side, drawing
// controls and ship position out to the self-drawing datapath.
interface player_ctrl_if #(
  parameter int XW = 8
);
  logic [3:0]    button;
  logic [3:0]    self_state;
  logic [1:0]    op;
  logic [XW-1:0] x;
  logic          self_enable;
  logic          fire_active;
  logic          fire_ready;
  logic [1:0]    fire_state;

  // No handshake: inputs are level signals sampled every clock; outputs are
  // valid every cycle outside reset. fire_state mirrors the fire FSM for debug.
  modport master (
    output button, self_state,
    input  op, x, self_enable, fire_active, fire_ready, fire_state
  );
  modport slave (
    input  button, self_state,
    output op, x, self_enable, fire_active, fire_ready, fire_state
  );
endinterface

// File: rtl/player_ctrl_param.sv
// Player-ship controller: synchronised active-low buttons, auto-repeat clamped
// movement, and a fire/cooldown FSM driving the self-drawing datapath.
module player_ctrl_param #(
  parameter int XW          = 8,
  parameter int X_INIT      = 82,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 150,
  parameter int STEP        = 10,
  parameter int MOVE_PERIOD = 25000000,
  parameter int FIRE_LEN    = 1250000,
  parameter int COOL_LEN    = 48750000,
  parameter int AUTO_FIRE   = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  player_ctrl_if.slave  bus
);

  localparam int MOVE_LOAD_I = MOVE_PERIOD - 1;
  localparam int FIRE_LOAD_I = FIRE_LEN - 1;
  localparam int COOL_LOAD_I = (COOL_LEN > 0) ? COOL_LEN - 1 : 0;
  localparam int FC_MAX      = (FIRE_LOAD_I > COOL_LOAD_I) ? FIRE_LOAD_I : COOL_LOAD_I;
  // +1 so a power-of-two load value still fits.
  localparam int MW = (MOVE_LOAD_I > 0) ? $clog2(MOVE_LOAD_I + 1) : 1;
  localparam int FW = (FC_MAX > 0) ? $clog2(FC_MAX + 1) : 1;

  localparam logic [MW-1:0] MOVE_LOAD = MW'(MOVE_LOAD_I);
  localparam logic [FW-1:0] FIRE_LOAD = FW'(FIRE_LOAD_I);
  localparam logic [FW-1:0] COOL_LOAD = FW'(COOL_LOAD_I);
  localparam logic          HAS_COOL  = (COOL_LEN > 0);
  localparam logic          AUTO      = (AUTO_FIRE != 0);

  localparam logic [XW:0]   STEP_E    = (XW+1)'(STEP);
  localparam logic [XW:0]   XMAX_E    = (XW+1)'(X_MAX);
  localparam logic [XW:0]   LEFT_LIM  = (XW+1)'(X_MIN + STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_COOL = 2'd2
  } fire_state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_t;

  logic [3:0]    r_btn_s1;
  logic [3:0]    r_btn_s2;
  logic [XW-1:0] r_x;
  logic [MW-1:0] r_mctr;
  dir_t          r_prev_dir;
  fire_state_t   r_state;
  logic [FW-1:0] r_fctr;
  logic          r_fire_prev;

  logic          w_right;
  logic          w_left;
  logic          w_fire;
  logic          w_alive;
  logic          w_fire_req;
  dir_t          w_dir;
  logic [XW:0]   w_sum;
  logic [XW-1:0] w_x_right;
  logic [XW-1:0] w_x_left;
  logic [XW-1:0] w_x_move;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_s1 <= 4'hF;
      r_btn_s2 <= 4'hF;
    end else begin
      r_btn_s1 <= bus.button;
      r_btn_s2 <= r_btn_s1;
    end
  end

  assign w_right    = ~r_btn_s2[0];
  assign w_left     = ~r_btn_s2[1];
  assign w_fire     = ~r_btn_s2[3];
  assign w_alive    = (bus.self_state == 4'd1);
  assign w_fire_req = (w_fire & ~r_fire_prev) | (AUTO & w_fire);

  always_comb begin
    w_dir = DIR_NONE;
    if (w_right && !w_left)      w_dir = DIR_RIGHT;
    else if (w_left && !w_right) w_dir = DIR_LEFT;
  end

  // Clamp in XW+1 bits so neither direction can wrap.
  always_comb begin
    w_sum     = {1'b0, r_x} + STEP_E;
    w_x_right = (w_sum > XMAX_E) ? XW'(X_MAX) : w_sum[XW-1:0];
    w_x_left  = ({1'b0, r_x} < LEFT_LIM) ? XW'(X_MIN) : (r_x - XW'(STEP));
    w_x_move  = (w_dir == DIR_RIGHT) ? w_x_right : w_x_left;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x        <= XW'(X_INIT);
      r_mctr     <= '0;
      r_prev_dir <= DIR_NONE;
    end else if (!w_alive || w_dir == DIR_NONE) begin
      r_mctr     <= '0;
      r_prev_dir <= DIR_NONE;
    end else if (w_dir != r_prev_dir) begin
      r_x        <= w_x_move;
      r_mctr     <= MOVE_LOAD;
      r_prev_dir <= w_dir;
    end else if (r_mctr == '0) begin
      r_x        <= w_x_move;
      r_mctr     <= MOVE_LOAD;
    end else begin
      r_mctr     <= r_mctr - MW'(1);
    end
  end

  // Edge history follows the synced fire bit in every state, so a press held
  // through cooldown is not seen as a new edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_fctr      <= '0;
      r_fire_prev <= 1'b0;
    end else begin
      r_fire_prev <= w_fire;
      case (r_state)
        ST_IDLE: begin
          if (w_fire_req && w_alive) begin
            r_state <= ST_FIRE;
            r_fctr  <= FIRE_LOAD;
          end
        end
        ST_FIRE: begin
          if (!w_alive) begin
            r_state <= ST_IDLE;
            r_fctr  <= '0;
          end else if (r_fctr == '0) begin
            r_state <= HAS_COOL ? ST_COOL : ST_IDLE;
            r_fctr  <= HAS_COOL ? COOL_LOAD : '0;
          end else begin
            r_fctr  <= r_fctr - FW'(1);
          end
        end
        ST_COOL: begin
          if (!w_alive || r_fctr == '0) begin
            r_state <= ST_IDLE;
            r_fctr  <= '0;
          end else begin
            r_fctr  <= r_fctr - FW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_fctr  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.op          = 2'b00;
    bus.self_enable = 1'b0;
    if (w_alive) begin
      bus.self_enable = 1'b1;
      bus.op          = (r_state == ST_FIRE) ? 2'b10 : 2'b00;
    end else if (bus.self_state == 4'd2) begin
      bus.self_enable = 1'b1;
      bus.op          = 2'b01;
    end
  end

  assign bus.x           = r_x;
  assign bus.fire_active = (r_state == ST_FIRE);
  assign bus.fire_ready  = (r_state == ST_IDLE) && w_alive;
  assign bus.fire_state  = r_state;

endmodule

// File: tb/tb_player_ctrl_param.sv
// Bench for player_ctrl_param: one edge-only and one auto-fire instance share
// stimulus; a behavioural model is compared every cycle plus literal checkpoints.
module tb_player_ctrl_param;

  localparam int XW          = 8;
  localparam int X_INIT      = 82;
  localparam int X_MIN       = 0;
  localparam int X_MAX       = 150;
  localparam int STEP        = 10;
  localparam int MOVE_PERIOD = 4;
  localparam int FIRE_LEN    = 3;
  localparam int COOL_LEN    = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] tb_button = 4'hF;
  logic [3:0] tb_self_state = 4'd0;
  bit         started = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  player_ctrl_if #(.XW(XW)) if0 ();
  player_ctrl_if #(.XW(XW)) if1 ();

  assign if0.button     = tb_button;
  assign if0.self_state = tb_self_state;
  assign if1.button     = tb_button;
  assign if1.self_state = tb_self_state;

  player_ctrl_param #(
    .XW(XW), .X_INIT(X_INIT), .X_MIN(X_MIN), .X_MAX(X_MAX), .STEP(STEP),
    .MOVE_PERIOD(MOVE_PERIOD), .FIRE_LEN(FIRE_LEN), .COOL_LEN(COOL_LEN), .AUTO_FIRE(0)
  ) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));

  player_ctrl_param #(
    .XW(XW), .X_INIT(X_INIT), .X_MIN(X_MIN), .X_MAX(X_MAX), .STEP(STEP),
    .MOVE_PERIOD(MOVE_PERIOD), .FIRE_LEN(FIRE_LEN), .COOL_LEN(COOL_LEN), .AUTO_FIRE(1)
  ) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

  // clock
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_held counts consecutive cycles a direction has been applied; a move
  // happens on every multiple of MOVE_PERIOD. m_age is cycles since a shot
  // started (-1 when idle); the shot owns FIRE_LEN+COOL_LEN cycles.
  logic [3:0] m_s1, m_s2;
  int         m_x, m_held, m_dir;
  bit         m_fprev;
  int         m_age [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 4'hF; m_s2 = 4'hF;
      m_x = X_INIT; m_held = 0; m_dir = 0; m_fprev = 1'b0;
      m_age[0] = -1; m_age[1] = -1;
    end else begin
      bit alive, r, l, f, edge_seen;
      int d;
      alive = (tb_self_state == 4'd1);
      r = ~m_s2[0]; l = ~m_s2[1]; f = ~m_s2[3];
      d = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
      if (alive && d != 0) begin
        if (d != m_dir) m_held = 0;
        else m_held = m_held + 1;
        m_dir = d;
        if (m_held % MOVE_PERIOD == 0) begin
          if (d > 0) m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
          else       m_x = (m_x - STEP < X_MIN) ? X_MIN : m_x - STEP;
        end
      end else begin
        m_held = 0; m_dir = 0;
      end
      edge_seen = f && !m_fprev;
      m_fprev = f;
      for (int i = 0; i < 2; i++) begin
        if (m_age[i] >= 0) begin
          if (!alive) m_age[i] = -1;
          else begin
            m_age[i] = m_age[i] + 1;
            if (m_age[i] >= FIRE_LEN + COOL_LEN) m_age[i] = -1;
          end
        end else if (alive && (edge_seen || (i == 1 && f))) begin
          m_age[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = tb_button;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [1:0] op, input logic [XW-1:0] x,
                          input logic en, input logic fa, input logic fr);
    bit alive, e_fa;
    int e_op;
    alive = (tb_self_state == 4'd1);
    e_fa  = (m_age[i] >= 0) && (m_age[i] < FIRE_LEN);
    e_op  = alive ? (e_fa ? 2 : 0) : ((tb_self_state == 4'd2) ? 1 : 0);
    chk($sformatf("x[%0d]", i), int'(x), m_x);
    chk($sformatf("op[%0d]", i), int'(op), e_op);
    chk($sformatf("self_enable[%0d]", i), int'(en), int'(alive || tb_self_state == 4'd2));
    chk($sformatf("fire_active[%0d]", i), int'(fa), int'(e_fa));
    chk($sformatf("fire_ready[%0d]", i), int'(fr), int'(alive && m_age[i] < 0));
  endtask

  always @(negedge clk) begin
    if (started && reset_n) begin
      cmp_inst(0, if0.op, if0.x, if0.self_enable, if0.fire_active, if0.fire_ready);
      cmp_inst(1, if1.op, if1.x, if1.self_enable, if1.fire_active, if1.fire_ready);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    cycles(1);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int saved_x;
    cycles(3);
    reset_n = 1'b1;
    #1;
    chk("reset_x", int'(if0.x), 82);
    chk("reset_op", int'(if0.op), 0);
    chk("reset_en", int'(if0.self_enable), 0);
    chk("reset_ready", int'(if0.fire_ready), 0);
    started = 1'b1;
    tb_self_state = 4'd1;
    #1;
    chk("alive_ready", int'(if0.fire_ready), 1);

    // right held for 9 synced cycles: moves at synced cycles 0, 4, 8
    tb_button = 4'b1110;
    cycles(4);  chk("rep_x0", int'(if0.x), 92);
    cycles(4);  chk("rep_x4", int'(if0.x), 102);
    cycles(1);  tb_button = 4'hF;
    cycles(10); chk("rep_hold", int'(if0.x), 112);

    tb_button = 4'b1110;
    cycles(30); chk("clamp_max", int'(if0.x), 150);
    tb_button = 4'hF;
    cycles(4);

    pulse_reset();
    tb_button = 4'b1101;
    cycles(40); chk("clamp_min", int'(if0.x), 0);
    tb_button = 4'hF;
    cycles(4);

    saved_x = m_x;
    tb_button = 4'b1100;
    cycles(8);  chk("both_dirs", int'(if0.x), saved_x);
    tb_button = 4'hF;
    cycles(4);

    // fire held: 3 cycles FIRE, 5 cycles COOL; auto instance re-fires at once
    tb_button = 4'b0111;
    cycles(3);  chk("fire_op0", int'(if0.op), 2);
    cycles(2);  chk("fire_op2", int'(if0.op), 2);
    cycles(1);  chk("cool_op", int'(if0.op), 0);
                chk("cool_ready", int'(if0.fire_ready), 0);
    cycles(4);  chk("cool_end_ready", int'(if0.fire_ready), 0);
    cycles(1);  chk("idle_ready", int'(if0.fire_ready), 1);
                chk("auto_idle_ready", int'(if1.fire_ready), 1);
    cycles(1);  chk("auto_refire", int'(if1.fire_active), 1);
                chk("edge_no_refire", int'(if0.fire_active), 0);
    tb_button = 4'hF;
    cycles(12);

    // second press inside cooldown is dropped
    tb_button = 4'b0111; cycles(2);
    tb_button = 4'hF;    cycles(4);
    tb_button = 4'b0111; cycles(2);
    tb_button = 4'hF;    cycles(12);

    // hit during FIRE
    tb_button = 4'b0111;
    cycles(4);
    tb_self_state = 4'd2;
    #1;
    chk("hit_op", int'(if0.op), 1);
    chk("hit_en", int'(if0.self_enable), 1);
    cycles(1);  chk("hit_idle", int'(if0.fire_active), 0);
    tb_button = 4'hF;
    tb_self_state = 4'd1;
    cycles(10);

    // asynchronous reset in the middle of FIRE
    tb_button = 4'b1110; cycles(6);
    tb_button = 4'hF;    cycles(4);
    tb_button = 4'b0111;
    cycles(4);  chk("pre_reset_op", int'(if0.op), 2);
    #1 reset_n = 1'b0;
    #1;
    chk("async_op", int'(if0.op), 0);
    chk("async_x", int'(if0.x), 82);
    chk("async_fa", int'(if0.fire_active), 0);
    cycles(2);
    tb_button = 4'hF;
    reset_n = 1'b1;
    cycles(3);

    // randomized phase
    repeat (200) begin
      int r;
      tb_button = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      if (r < 7)       tb_self_state = 4'd1;
      else if (r == 7) tb_self_state = 4'd2;
      else if (r == 8) tb_self_state = 4'd0;
      else             tb_self_state = 4'($urandom_range(3, 15));
      cycles($urandom_range(1, 12));
    end
    tb_button = 4'hF;
    tb_self_state = 4'd1;
    cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
